// File: rtl/seq_det_pkg.sv
// Shared mode encodings and the run-link rule for the run sequence detector.
package seq_det_pkg;

  localparam logic [1:0] MODE_EITHER = 2'b00;
  localparam logic [1:0] MODE_ONES   = 2'b01;
  localparam logic [1:0] MODE_ZEROS  = 2'b10;
  localparam logic [1:0] MODE_ALT    = 2'b11;

  // A new sample extends the current run when it repeats the previous bit,
  // except in alternating mode where it must differ from it.
  function automatic logic link_ok(input logic [1:0] mode, input logic w, input logic last_w);
    if (mode == MODE_ALT) begin
      return (w != last_w);
    end
    return (w == last_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         ovf
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + W'(1);
  endfunction

  // Clear has priority; an increment at all-ones records overflow instead.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      q <= sat_inc(q);
      if (&q) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_sequence_detector.sv
// Run-length sequence detector: flags when the last RUN_LEN accepted samples
// form a qualifying run and counts each newly formed run.
module run_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8,
  localparam int RW     = $clog2(RUN_LEN + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             w,
  input  logic [1:0]       Mode,
  input  logic             Clr,
  output logic             z,
  output logic [RW-1:0]    run_len,
  output logic [CNT_W-1:0] hit_count,
  output logic             ovf
);

  if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
    $error("run_sequence_detector: RUN_LEN must be in 2..255");
  end

  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

  logic          valid;
  logic          last_w;
  logic [1:0]    mode_q;

  logic          valid_n;
  logic          last_w_n;
  logic [RW-1:0] run_len_n;
  logic          z_n;
  logic          hit_ev;

  // Run length grows by one per linked sample and holds once it reaches RUN_LEN.
  function automatic logic [RW-1:0] sat_run_inc(input logic [RW-1:0] v);
    if (v >= RUN_MAX) begin
      return RUN_MAX;
    end
    return v + RW'(1);
  endfunction

  // Polarity-restricted modes only qualify runs of the requested bit value.
  function automatic logic pol_ok(input logic [1:0] mode, input logic bit_v);
    case (mode)
      MODE_ONES:  return bit_v;
      MODE_ZEROS: return ~bit_v;
      default:    return 1'b1;
    endcase
  endfunction

  // Next-state for the run tracker, the detection flag and the event pulse.
  always_comb begin
    valid_n   = valid;
    last_w_n  = last_w;
    run_len_n = run_len;
    z_n       = z;
    if (Mode != mode_q) begin
      // A mode change restarts tracking and discards this edge's sample.
      valid_n   = 1'b0;
      run_len_n = '0;
      z_n       = 1'b0;
    end else if (En) begin
      last_w_n = w;
      valid_n  = 1'b1;
      if (!valid) begin
        run_len_n = RW'(1);
      end else if (link_ok(mode_q, w, last_w)) begin
        run_len_n = sat_run_inc(run_len);
      end else begin
        run_len_n = RW'(1);
      end
      z_n = (run_len_n == RUN_MAX) && pol_ok(mode_q, last_w_n);
    end
    hit_ev = z_n & ~z;
  end

  // Run tracker state, mode register and registered detection flag.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid   <= 1'b0;
      last_w  <= 1'b0;
      run_len <= '0;
      mode_q  <= MODE_EITHER;
      z       <= 1'b0;
    end else begin
      valid   <= valid_n;
      last_w  <= last_w_n;
      run_len <= run_len_n;
      mode_q  <= Mode;
      z       <= z_n;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_hit_counter (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (Clr),
    .inc    (hit_ev),
    .q      (hit_count),
    .ovf    (ovf)
  );

endmodule

// File: tb/tb_run_sequence_detector.sv
// Bench for run_sequence_detector: three parameterisations share one stimulus
// stream and are checked every cycle against a history-based reference model.
module tb_run_sequence_detector;

  logic       Clock;
  logic       Resetn;
  logic       En;
  logic       w;
  logic [1:0] Mode;
  logic       Clr;

  logic       z0, z1, z2;
  logic [1:0] r0, r1;
  logic [2:0] r2;
  logic [1:0] h0;
  logic [7:0] h1, h2;
  logic       o0, o1, o2;

  run_sequence_detector #(.RUN_LEN(2), .CNT_W(2)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Mode(Mode), .Clr(Clr),
    .z(z0), .run_len(r0), .hit_count(h0), .ovf(o0));
  run_sequence_detector #(.RUN_LEN(3), .CNT_W(8)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Mode(Mode), .Clr(Clr),
    .z(z1), .run_len(r1), .hit_count(h1), .ovf(o1));
  run_sequence_detector #(.RUN_LEN(4), .CNT_W(8)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .w(w), .Mode(Mode), .Clr(Clr),
    .z(z2), .run_len(r2), .hit_count(h2), .ovf(o2));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: the accepted samples since the last restart, from which
  // run length and detection are recomputed after every edge.
  int       RLS  [3] = '{2, 3, 4};
  int       CMAX [3] = '{3, 255, 255};
  bit       hist [$];
  bit [1:0] m_mode_q;
  int       m_run [3];
  bit       m_z   [3];
  int       m_cnt [3];
  bit       m_ovf [3];

  function automatic int run_of(input int rl, input bit [1:0] md);
    int n;
    if (hist.size() == 0) return 0;
    n = 1;
    for (int k = hist.size() - 1; k > 0; k--) begin
      if ((md == 2'b11) ? (hist[k] != hist[k-1]) : (hist[k] == hist[k-1])) n++;
      else break;
    end
    return (n > rl) ? rl : n;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hist.delete();
      m_mode_q = 2'b00;
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0; m_z[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      if (Mode != m_mode_q) hist.delete();
      else if (En) begin
        hist.push_back(w);
        if (hist.size() > 16) void'(hist.pop_front());
      end
      for (int i = 0; i < 3; i++) begin
        bit nz;
        bit pol;
        m_run[i] = run_of(RLS[i], Mode);
        pol = 1'b1;
        if (hist.size() > 0) begin
          if (Mode == 2'b01) pol = hist[hist.size()-1];
          if (Mode == 2'b10) pol = !hist[hist.size()-1];
        end
        nz = (m_run[i] == RLS[i]) && pol;
        if (Clr) begin
          m_cnt[i] = 0; m_ovf[i] = 0;
        end else if (nz && !m_z[i]) begin
          if (m_cnt[i] == CMAX[i]) m_ovf[i] = 1;
          else m_cnt[i]++;
        end
        m_z[i] = nz;
      end
      m_mode_q = Mode;
    end
  end

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dz(input int i);
    return (i == 0) ? {31'b0, z0} : (i == 1) ? {31'b0, z1} : {31'b0, z2};
  endfunction
  function automatic logic [31:0] dr(input int i);
    return (i == 0) ? {30'b0, r0} : (i == 1) ? {30'b0, r1} : {29'b0, r2};
  endfunction
  function automatic logic [31:0] dh(input int i);
    return (i == 0) ? {30'b0, h0} : (i == 1) ? {24'b0, h1} : {24'b0, h2};
  endfunction
  function automatic logic [31:0] dov(input int i);
    return (i == 0) ? {31'b0, o0} : (i == 1) ? {31'b0, o1} : {31'b0, o2};
  endfunction

  // Every-cycle comparison of all instances against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        cmp("z", i, dz(i), 32'(m_z[i]));
        cmp("run_len", i, dr(i), 32'(m_run[i]));
        cmp("hit_count", i, dh(i), 32'(m_cnt[i]));
        cmp("ovf", i, dov(i), 32'(m_ovf[i]));
      end
    end
  end

  task automatic step(input bit e, input bit ww, input bit c, input bit [1:0] md);
    @(negedge Clock);
    #1;
    En = e; w = ww; Clr = c; Mode = md;
    @(posedge Clock);
    #1;
  endtask

  bit ws_leg [6] = '{0, 0, 1, 1, 1, 0};
  bit zs_leg [6] = '{0, 1, 0, 1, 1, 0};
  bit ws_pol [6] = '{0, 0, 0, 1, 1, 1};
  bit zs_one [6] = '{0, 0, 0, 0, 0, 1};
  bit zs_zer [6] = '{0, 0, 1, 0, 0, 0};
  bit ws_alt [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit zs_alt [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  bit ws_cnt [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    Resetn = 1'b0; En = 1'b0; w = 1'b0; Mode = 2'b00; Clr = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    #1 Resetn = 1'b1;
    chk_en = 1'b1;

    // Legacy equal-bit behaviour, RUN_LEN=2, EITHER.
    for (int i = 0; i < 6; i++) begin
      step(1, ws_leg[i], 0, 2'b00);
      cmp("legacy_z", i, {31'b0, z0}, 32'(zs_leg[i]));
      cmp("legacy_model_z", i, 32'(m_z[0]), 32'(zs_leg[i]));
    end
    cmp("legacy_hits", 0, {30'b0, h0}, 32'd2);

    // Async reset in the middle of a held run.
    step(1, 0, 0, 2'b00);
    cmp("pre_reset_z", 0, {31'b0, z0}, 32'd1);
    #2 Resetn = 1'b0;
    #1;
    cmp("reset_z", 0, {31'b0, z0}, 32'd0);
    cmp("reset_run", 0, {30'b0, r0}, 32'd0);
    cmp("reset_hits", 0, {30'b0, h0}, 32'd0);
    cmp("reset_ovf", 0, {31'b0, o0}, 32'd0);
    @(negedge Clock);
    #1 Resetn = 1'b1;
    step(1, 1, 0, 2'b00);
    cmp("post_reset_run", 0, {30'b0, r0}, 32'd1);
    cmp("post_reset_z", 0, {31'b0, z0}, 32'd0);

    // Polarity modes, RUN_LEN=3.
    step(0, 0, 0, 2'b01);
    for (int i = 0; i < 6; i++) begin
      step(1, ws_pol[i], 0, 2'b01);
      cmp("ones_z", i, {31'b0, z1}, 32'(zs_one[i]));
    end
    step(0, 0, 0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      step(1, ws_pol[i], 0, 2'b10);
      cmp("zeros_z", i, {31'b0, z1}, 32'(zs_zer[i]));
      cmp("zeros_model_z", i, 32'(m_z[1]), 32'(zs_zer[i]));
    end

    // Alternating mode, RUN_LEN=4.
    step(0, 0, 0, 2'b11);
    for (int i = 0; i < 8; i++) begin
      step(1, ws_alt[i], 0, 2'b11);
      cmp("alt_z", i, {31'b0, z2}, 32'(zs_alt[i]));
      if (i == 4) cmp("alt_run_break", i, {29'b0, r2}, 32'd1);
    end

    // En gating then a mode change, RUN_LEN=2.
    step(0, 0, 0, 2'b00);
    step(1, 1, 0, 2'b00);
    for (int i = 0; i < 5; i++) step(0, 1'(i), 0, 2'b00);
    cmp("gated_z", 0, {31'b0, z0}, 32'd0);
    step(1, 1, 0, 2'b00);
    cmp("gate_resume_z", 0, {31'b0, z0}, 32'd1);
    step(1, 1, 0, 2'b01);
    cmp("modechg_z", 0, {31'b0, z0}, 32'd0);
    cmp("modechg_run", 0, {30'b0, r0}, 32'd0);

    // Saturating counter, CNT_W=2.
    step(0, 0, 1, 2'b00);
    for (int i = 0; i < 10; i++) step(1, ws_cnt[i], 0, 2'b00);
    cmp("sat_hits", 0, {30'b0, h0}, 32'd3);
    cmp("sat_ovf", 0, {31'b0, o0}, 32'd1);
    cmp("model_sat_ovf", 0, 32'(m_ovf[0]), 32'd1);
    step(1, 1, 0, 2'b00);
    step(1, 1, 1, 2'b00);
    cmp("clr_event_z", 0, {31'b0, z0}, 32'd1);
    cmp("clr_event_hits", 0, {30'b0, h0}, 32'd0);
    cmp("clr_event_ovf", 0, {31'b0, o0}, 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      bit [1:0] md;
      md = Mode;
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        @(negedge Clock);
        #1 Resetn = 1'b0;
        #2 Resetn = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0, md);
    end

    @(negedge Clock);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
